// File: rtl/keypad_pkg.sv
// Shared constants for the keypad password lock: key codes, FSM state
// encoding and small helper functions used by the controller.
package keypad_pkg;

  localparam logic [3:0] KEY_A    = 4'ha;
  localparam logic [3:0] KEY_B    = 4'hb;
  localparam logic [3:0] KEY_STAR = 4'he;
  localparam logic [3:0] KEY_HASH = 4'hf;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOCKOUT = 3'd4,
    ST_SETPW   = 3'd5
  } state_t;

  // True for the decimal digit keys 0-9.
  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  // Largest of the three timed-state durations; sizes the shared timer.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the FAIL, LOCKOUT and OPEN states.
// Counts down to zero and then holds; a load always takes priority.
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero,
  output logic         busy
);

  logic [W-1:0] count_r;

  // Counter register: load wins, otherwise decrement until zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});
  assign busy = (count_r != {W{1'b0}});

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Password lock controller: turns one-cycle key events from the keypad
// scanner into digit entry, verification, unlock, relock and re-program.
module keypad_lock_ctrl
  import keypad_pkg::*;
#(
  parameter int                    DIGITS      = 4,
  parameter logic [4*DIGITS-1:0]   INIT_PW     = 16'h1234,
  parameter int                    MAX_TRIES   = 3,
  parameter int unsigned           FAIL_CYCLES = 50_000_000,
  parameter int unsigned           LOCK_CYCLES = 500_000_000,
  parameter int unsigned           OPEN_CYCLES = 250_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         key_valid,
  input  logic [3:0]                   key_code,
  output logic [4*DIGITS-1:0]          entry_digits,
  output logic [$clog2(DIGITS+1)-1:0]  entry_count,
  output logic [2:0]                   state_code,
  output logic                         unlocked,
  output logic                         err,
  output logic                         alarm,
  output logic [2:0]                   fail_count
);

  localparam int          PW   = 4 * DIGITS;
  localparam int          CW   = $clog2(DIGITS + 1);
  localparam int unsigned MAXC = max3(FAIL_CYCLES, LOCK_CYCLES, OPEN_CYCLES);
  localparam int          TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] FULL      = CW'(DIGITS);
  localparam logic [TW-1:0] FAIL_LOAD = TW'(FAIL_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);

  state_t          state_r, next_state_s;
  logic [PW-1:0]   buf_r, buf_next_s;
  logic [PW-1:0]   pw_r, pw_next_s;
  logic [CW-1:0]   cnt_r, cnt_next_s;
  logic [2:0]      fail_r, fail_next_s, fail_inc_s;
  logic            t_load_s, t_zero_s, t_busy_s;
  logic [TW-1:0]   t_val_s;
  logic            unlocked_s, err_s, alarm_s;
  logic            unlocked_r, err_r, alarm_r;

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load_s),
    .load_val (t_val_s),
    .zero     (t_zero_s),
    .busy     (t_busy_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_ENTRY;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state, entry buffer, password, fail count and timer reload.
  always_comb begin
    next_state_s = state_r;
    buf_next_s   = buf_r;
    cnt_next_s   = cnt_r;
    pw_next_s    = pw_r;
    fail_next_s  = fail_r;
    fail_inc_s   = fail_r + 3'd1;
    t_load_s     = 1'b0;
    t_val_s      = {TW{1'b0}};
    case (state_r)
      ST_ENTRY, ST_SETPW: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            if (cnt_r < FULL) begin
              buf_next_s = (buf_r << 4) | PW'(key_code);
              cnt_next_s = cnt_r + CW'(1);
            end else begin
              buf_next_s = buf_r;
            end
          end else if (key_code == KEY_B) begin
            if (cnt_r != {CW{1'b0}}) begin
              buf_next_s = buf_r >> 4;
              cnt_next_s = cnt_r - CW'(1);
            end else begin
              buf_next_s = buf_r;
            end
          end else if (key_code == KEY_STAR) begin
            // Clears entry; from SETPW this is an abort back to ENTRY.
            buf_next_s   = {PW{1'b0}};
            cnt_next_s   = {CW{1'b0}};
            next_state_s = ST_ENTRY;
          end else if ((key_code == KEY_HASH) && (cnt_r == FULL)) begin
            if (state_r == ST_ENTRY) begin
              next_state_s = ST_CHECK;
            end else begin
              pw_next_s    = buf_r;
              buf_next_s   = {PW{1'b0}};
              cnt_next_s   = {CW{1'b0}};
              next_state_s = ST_ENTRY;
            end
          end else begin
            next_state_s = state_r;
          end
        end else begin
          next_state_s = state_r;
        end
      end
      ST_CHECK: begin
        buf_next_s = {PW{1'b0}};
        cnt_next_s = {CW{1'b0}};
        t_load_s   = 1'b1;
        if (buf_r == pw_r) begin
          next_state_s = ST_OPEN;
          fail_next_s  = 3'd0;
          t_val_s      = OPEN_LOAD;
        end else if (fail_inc_s == 3'(MAX_TRIES)) begin
          next_state_s = ST_LOCKOUT;
          fail_next_s  = fail_inc_s;
          t_val_s      = LOCK_LOAD;
        end else begin
          next_state_s = ST_FAIL;
          fail_next_s  = fail_inc_s;
          t_val_s      = FAIL_LOAD;
        end
      end
      ST_OPEN: begin
        // Expiry is tested first so a coincident key is dropped.
        if (!t_busy_s) begin
          next_state_s = ST_ENTRY;
        end else if (key_valid && (key_code == KEY_STAR)) begin
          next_state_s = ST_ENTRY;
          t_load_s     = 1'b1;
        end else if (key_valid && (key_code == KEY_A)) begin
          next_state_s = ST_SETPW;
          buf_next_s   = {PW{1'b0}};
          cnt_next_s   = {CW{1'b0}};
          t_load_s     = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_FAIL: begin
        if (t_zero_s) begin
          next_state_s = ST_ENTRY;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_LOCKOUT: begin
        if (t_zero_s) begin
          next_state_s = ST_ENTRY;
          fail_next_s  = 3'd0;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = ST_ENTRY;
      end
    endcase
  end

  // Status flags derived from the state being entered, so they register with it.
  always_comb begin
    unlocked_s = 1'b0;
    err_s      = 1'b0;
    alarm_s    = 1'b0;
    case (next_state_s)
      ST_OPEN, ST_SETPW: unlocked_s = 1'b1;
      ST_FAIL:           err_s      = 1'b1;
      ST_LOCKOUT:        alarm_s    = 1'b1;
      default:           unlocked_s = 1'b0;
    endcase
  end

  // Datapath and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_r      <= {PW{1'b0}};
      cnt_r      <= {CW{1'b0}};
      pw_r       <= INIT_PW;
      fail_r     <= 3'd0;
      unlocked_r <= 1'b0;
      err_r      <= 1'b0;
      alarm_r    <= 1'b0;
    end else begin
      buf_r      <= buf_next_s;
      cnt_r      <= cnt_next_s;
      pw_r       <= pw_next_s;
      fail_r     <= fail_next_s;
      unlocked_r <= unlocked_s;
      err_r      <= err_s;
      alarm_r    <= alarm_s;
    end
  end

  assign entry_digits = buf_r;
  assign entry_count  = cnt_r;
  assign state_code   = state_r;
  assign unlocked     = unlocked_r;
  assign err          = err_r;
  assign alarm        = alarm_r;
  assign fail_count   = fail_r;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Self-checking bench for keypad_lock_ctrl with short timed states.
// The reference model tracks the entry as a digit queue and the timed
// states as remaining-cycle counts.
module tb_keypad_lock_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry_digits;
  logic [2:0]  entry_count;
  logic [2:0]  state_code;
  logic        unlocked, err, alarm;
  logic [2:0]  fail_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_state;
  int m_q[$];
  int m_pw[4];
  int m_fail;
  int m_left;

  keypad_lock_ctrl #(
    .DIGITS(4), .INIT_PW(16'h1234), .MAX_TRIES(3),
    .FAIL_CYCLES(4), .LOCK_CYCLES(8), .OPEN_CYCLES(6)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .entry_digits(entry_digits), .entry_count(entry_count),
    .state_code(state_code), .unlocked(unlocked), .err(err),
    .alarm(alarm), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_state = 0;
    m_q.delete();
    m_pw = '{1, 2, 3, 4};
    m_fail = 0;
    m_left = 0;
  endfunction

  function automatic void model_step(input logic kv, input logic [3:0] kc);
    int k;
    bit same;
    k = int'(kc);
    case (m_state)
      0, 5: begin
        if (kv) begin
          if (k <= 9) begin
            if (m_q.size() < 4) m_q.push_back(k);
          end else if (k == 11) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
          end else if (k == 14) begin
            m_q.delete();
            m_state = 0;
          end else if (k == 15 && m_q.size() == 4) begin
            if (m_state == 0) m_state = 1;
            else begin
              for (int i = 0; i < 4; i++) m_pw[i] = m_q[i];
              m_q.delete();
              m_state = 0;
            end
          end
        end
      end
      1: begin
        same = 1'b1;
        for (int i = 0; i < 4; i++) if (m_q[i] != m_pw[i]) same = 1'b0;
        m_q.delete();
        if (same) begin
          m_state = 2; m_fail = 0; m_left = 6;
        end else begin
          m_fail++;
          if (m_fail == 3) begin m_state = 4; m_left = 8; end
          else begin m_state = 3; m_left = 4; end
        end
      end
      2: begin
        m_left--;
        if (m_left == 0) m_state = 0;
        else if (kv && k == 14) begin m_state = 0; m_left = 0; end
        else if (kv && k == 10) begin m_state = 5; m_q.delete(); m_left = 0; end
      end
      3: begin
        m_left--;
        if (m_left == 0) m_state = 0;
      end
      4: begin
        m_left--;
        if (m_left == 0) begin m_state = 0; m_fail = 0; end
      end
      default: m_state = 0;
    endcase
  endfunction

  function automatic logic [27:0] exp_vec();
    logic [15:0] d;
    d = 16'h0000;
    foreach (m_q[i]) d = {d[11:0], 4'(m_q[i])};
    return {3'(m_state), 1'(m_state == 2 || m_state == 5), 1'(m_state == 3),
            1'(m_state == 4), 3'(m_fail), 3'(m_q.size()), d};
  endfunction

  function automatic logic [27:0] dut_vec();
    return {state_code, unlocked, err, alarm, fail_count, entry_count, entry_digits};
  endfunction

  task automatic step(input logic kv, input logic [3:0] kc);
    @(negedge clk);
    key_valid = kv;
    key_code  = kc;
    @(posedge clk);
    model_step(kv, kc);
    #1;
    key_valid = 1'b0;
    key_code  = 4'($urandom);
  endtask

  task automatic idle_to_entry(output int n);
    n = 0;
    while (m_state != 0 && n < 40) begin
      step(1'b0, 4'($urandom));
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_values got=%h exp=%h", dut_vec(), exp_vec());
    end
    @(negedge clk); reset = 1'b0;
    step(1'b0, 4'h0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_unlock();
    logic [19:0] keys = 20'h1234f;
    int ucnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, keys[4*(4-i) +: 4]);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL unlock_key%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (state_code !== 3'd1) begin
      failures++; $display("FAIL unlock_check_state got=%0d exp=1", state_code);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'($urandom));
      if (unlocked === 1'b1) ucnt++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL unlock_idle%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (ucnt !== 6) begin
      failures++; $display("FAIL unlock_open_len got=%0d exp=6", ucnt);
    end
    checks++;
    if (state_code !== 3'd0 || unlocked !== 1'b0 || fail_count !== 3'd0) begin
      failures++; $display("FAIL unlock_relock got=%0d/%b/%0d exp=0/0/0", state_code, unlocked, fail_count);
    end
  endtask

  task automatic test_fail_lockout();
    logic [19:0] keys = 20'h1239f;
    int ecnt = 0;
    int acnt = 0;
    int n;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        step(1'b1, keys[4*(4-i) +: 4]);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          failures++; $display("FAIL bad_key r%0d k%0d got=%h exp=%h", r, i, dut_vec(), exp_vec());
        end
      end
      n = 0;
      while (m_state != 0 && n < 20) begin
        step(1'($urandom), 4'($urandom));
        n++;
        if (err === 1'b1) ecnt++;
        if (alarm === 1'b1) acnt++;
        checks++;
        if (dut_vec() !== exp_vec()) begin
          failures++; $display("FAIL timed_hold r%0d c%0d got=%h exp=%h", r, n, dut_vec(), exp_vec());
        end
      end
    end
    checks++;
    if (ecnt !== 8 || acnt !== 8) begin
      failures++; $display("FAIL err_alarm_len got=%0d/%0d exp=8/8", ecnt, acnt);
    end
    checks++;
    if (fail_count !== 3'd0 || state_code !== 3'd0) begin
      failures++; $display("FAIL lockout_exit got=%0d/%0d exp=0/0", fail_count, state_code);
    end
  endtask

  task automatic test_edit();
    logic [19:0] keys = 20'h12345;
    int n;
    for (int i = 0; i < 5; i++) step(1'b1, keys[4*(4-i) +: 4]);
    checks++;
    if (entry_digits !== 16'h1234 || entry_count !== 3'd4) begin
      failures++; $display("FAIL edit_overflow got=%h/%0d exp=1234/4", entry_digits, entry_count);
    end
    step(1'b1, 4'hb);
    checks++;
    if (entry_digits !== 16'h0123 || entry_count !== 3'd3) begin
      failures++; $display("FAIL edit_backspace got=%h/%0d exp=0123/3", entry_digits, entry_count);
    end
    step(1'b1, 4'h4);
    step(1'b1, 4'hf);
    step(1'b0, 4'h0);
    checks++;
    if (unlocked !== 1'b1 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL edit_unlock got=%h exp=%h", dut_vec(), exp_vec());
    end
    idle_to_entry(n);
    step(1'b1, 4'h1); step(1'b1, 4'h2); step(1'b1, 4'he);
    checks++;
    if (entry_digits !== 16'h0000 || entry_count !== 3'd0) begin
      failures++; $display("FAIL edit_clear got=%h/%0d exp=0000/0", entry_digits, entry_count);
    end
    step(1'b1, 4'h1); step(1'b1, 4'h2); step(1'b1, 4'hf);
    checks++;
    if (state_code !== 3'd0 || entry_digits !== 16'h0012 || entry_count !== 3'd2) begin
      failures++; $display("FAIL edit_short_hash got=%0d/%h/%0d exp=0/0012/2", state_code, entry_digits, entry_count);
    end
    step(1'b1, 4'hb); step(1'b1, 4'hb); step(1'b1, 4'hb);
    checks++;
    if (dut_vec() !== exp_vec() || entry_count !== 3'd0) begin
      failures++; $display("FAIL edit_bs_empty got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_expiry_collision();
    logic [3:0] coll [2];
    int g;
    coll[0] = 4'ha;
    coll[1] = 4'he;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 4; i++) step(1'b1, 4'(m_pw[i]));
      step(1'b1, 4'hf);
      step(1'b0, 4'h0);
      g = 0;
      while (m_left != 1 && g < 20) begin step(1'b0, 4'h0); g++; end
      checks++;
      if (unlocked !== 1'b1) begin
        failures++; $display("FAIL expiry_pre%0d got=%b exp=1", c, unlocked);
      end
      step(1'b1, coll[c]);
      checks++;
      if (state_code !== 3'd0 || unlocked !== 1'b0 || dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL expiry_collide%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_setpw();
    logic [23:0] seq = 24'ha9876f;
    logic [19:0] oldk = 20'h1234f;
    logic [19:0] newk = 20'h9876f;
    int n;
    for (int i = 0; i < 5; i++) step(1'b1, oldk[4*(4-i) +: 4]);
    step(1'b0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, seq[4*(5-i) +: 4]);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL setpw_key%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (state_code !== 3'd0 || unlocked !== 1'b0) begin
      failures++; $display("FAIL setpw_done got=%0d/%b exp=0/0", state_code, unlocked);
    end
    for (int i = 0; i < 5; i++) step(1'b1, oldk[4*(4-i) +: 4]);
    step(1'b0, 4'h0);
    checks++;
    if (err !== 1'b1 || state_code !== 3'd3) begin
      failures++; $display("FAIL setpw_old_rejected got=%b/%0d exp=1/3", err, state_code);
    end
    idle_to_entry(n);
    for (int i = 0; i < 5; i++) step(1'b1, newk[4*(4-i) +: 4]);
    step(1'b0, 4'h0);
    checks++;
    if (unlocked !== 1'b1 || fail_count !== 3'd0) begin
      failures++; $display("FAIL setpw_new_accepted got=%b/%0d exp=1/0", unlocked, fail_count);
    end
    idle_to_entry(n);
    checks++;
    if (state_code !== 3'd0) begin
      failures++; $display("FAIL setpw_relock got=%0d exp=0", state_code);
    end
  endtask

  task automatic test_reset_lockout();
    logic [19:0] bad = 20'h1111f;
    logic [19:0] good = 20'h1234f;
    int n;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) step(1'b1, bad[4*(4-i) +: 4]);
      if (r < 2) idle_to_entry(n);
    end
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    checks++;
    if (alarm !== 1'b1) begin
      failures++; $display("FAIL lockout_reached got=%b exp=1", alarm);
    end
    #1 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), exp_vec());
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, good[4*(4-i) +: 4]);
    step(1'b0, 4'h0);
    checks++;
    if (unlocked !== 1'b1 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_pw_restored got=%h exp=%h", dut_vec(), exp_vec());
    end
    idle_to_entry(n);
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(99, 0);
      if (r < 8 && (m_state == 0 || m_state == 5)) begin
        for (int i = 0; i < 4; i++) step(1'b1, 4'(m_pw[i]));
        step(1'b1, 4'hf);
      end else if (r < 60) begin
        step(1'b1, 4'($urandom_range(9, 0)));
      end else if (r < 85) begin
        step(1'b1, 4'($urandom_range(15, 10)));
      end else begin
        step(1'b0, 4'($urandom));
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL random_c%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_fail_lockout();
    test_edit();
    test_expiry_collision();
    test_setpw();
    test_reset_lockout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
